// File: rtl/ysyx_22040386_pmem_responder_if.sv
// rtl/ysyx_22040386_pmem_responder_if.sv - request/response bus between MEMU and the pmem responder
//
// Purpose: groups the load/store request channel and the completion channel.
// Signals:
//   req_valid/req_ready  request handshake
//   req_wen              1 = write, 0 = read
//   req_addr             byte address (bits [2:0] ignored by the responder)
//   req_wdata/req_wmask  lane-aligned write data and byte enables
//   rsp_valid/rsp_ready  response handshake
//   rsp_rdata/rsp_err    read data (0 for writes/errors) and out-of-range flag
// Modports: master = core side, slave = responder side.
interface ysyx_22040386_pmem_responder_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_wen;
    logic [63:0] req_addr;
    logic [63:0] req_wdata;
    logic [7:0]  req_wmask;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [63:0] rsp_rdata;
    logic        rsp_err;

    modport master (
        output req_valid, req_wen, req_addr, req_wdata, req_wmask, rsp_ready,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err
    );

    modport slave (
        input  req_valid, req_wen, req_addr, req_wdata, req_wmask, rsp_ready,
        output req_ready, rsp_valid, rsp_rdata, rsp_err
    );
endinterface

// File: rtl/ysyx_22040386_pmem_responder.sv
// rtl/ysyx_22040386_pmem_responder.sv - fixed-latency synthesizable pmem responder for the core's load/store port
//
// Purpose: accepts one read or byte-masked write at a time, waits LATENCY cycles,
// performs the access on an internal doubleword array and returns a completion.
// Ports:
//   clk   in  clock, all state changes on posedge
//   rst   in  synchronous active-high reset (array contents are preserved)
//   pmem  slave modport of ysyx_22040386_pmem_responder_if (request + response channels)
// Parameters:
//   BASE_ADDR   byte address of doubleword 0
//   DEPTH_LOG2  log2 of number of 64-bit words
//   LATENCY     WAIT cycles between accept and access (0 = access on the accept edge)
module ysyx_22040386_pmem_responder #(
    parameter logic [63:0] BASE_ADDR  = 64'h8000_0000,
    parameter int          DEPTH_LOG2 = 12,
    parameter int          LATENCY    = 2
) (
    input  logic                            clk,
    input  logic                            rst,
    ysyx_22040386_pmem_responder_if.slave   pmem
);
    localparam int DEPTH    = 1 << DEPTH_LOG2;
    localparam int CNT_W    = (LATENCY > 1) ? $clog2(LATENCY) : 1;
    localparam bit ZERO_LAT = (LATENCY == 0);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_WAIT = 2'd1;
    localparam logic [1:0] S_RESP = 2'd2;

    logic [1:0]       r_state;
    logic [CNT_W-1:0] r_cnt;
    logic             r_wen;
    logic [63:0]      r_addr;
    logic [63:0]      r_wdata;
    logic [7:0]       r_wmask;
    logic [63:0]      r_rdata;
    logic             r_err;
    logic [63:0]      r_mem [DEPTH];

    logic                  w_accept;
    logic                  w_do_access;
    logic                  w_acc_wen;
    logic [63:0]           w_acc_addr;
    logic [63:0]           w_acc_wdata;
    logic [7:0]            w_acc_wmask;
    logic [63:0]           w_off;
    logic                  w_hit;
    logic [DEPTH_LOG2-1:0] w_idx;

    assign pmem.req_ready = (r_state == S_IDLE);
    assign pmem.rsp_valid = (r_state == S_RESP);
    assign pmem.rsp_rdata = r_rdata;
    assign pmem.rsp_err   = r_err;

    assign w_accept = pmem.req_valid && (r_state == S_IDLE) && !rst;

    // With zero latency the access happens on the accept edge, so the operands
    // come straight from the bus instead of the latched copies.
    assign w_acc_wen   = ZERO_LAT ? pmem.req_wen   : r_wen;
    assign w_acc_addr  = ZERO_LAT ? pmem.req_addr  : r_addr;
    assign w_acc_wdata = ZERO_LAT ? pmem.req_wdata : r_wdata;
    assign w_acc_wmask = ZERO_LAT ? pmem.req_wmask : r_wmask;

    assign w_do_access = ZERO_LAT ? w_accept
                                  : ((r_state == S_WAIT) && (r_cnt == '0) && !rst);

    // Range check via offset: no upper-bound add, so BASE_ADDR near the top of
    // the address space cannot wrap the limit.
    assign w_off = w_acc_addr - BASE_ADDR;
    assign w_hit = (w_acc_addr >= BASE_ADDR) && ((w_off >> (DEPTH_LOG2 + 3)) == 64'd0);
    assign w_idx = w_off[DEPTH_LOG2+2:3];

    // Storage is intentionally not reset.
    always_ff @(posedge clk) begin
        if (w_do_access && w_acc_wen && w_hit) begin
            for (int i = 0; i < 8; i++) begin
                if (w_acc_wmask[i]) begin
                    r_mem[w_idx][8*i +: 8] <= w_acc_wdata[8*i +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_wen   <= 1'b0;
            r_addr  <= 64'd0;
            r_wdata <= 64'd0;
            r_wmask <= 8'd0;
            r_rdata <= 64'd0;
            r_err   <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (pmem.req_valid) begin
                        r_wen   <= pmem.req_wen;
                        r_addr  <= pmem.req_addr;
                        r_wdata <= pmem.req_wdata;
                        r_wmask <= pmem.req_wmask;
                        if (ZERO_LAT) begin
                            r_state <= S_RESP;
                        end else begin
                            r_state <= S_WAIT;
                            r_cnt   <= CNT_W'(LATENCY - 1);
                        end
                    end
                end
                S_WAIT: begin
                    if (r_cnt == '0) begin
                        r_state <= S_RESP;
                    end else begin
                        r_cnt <= r_cnt - CNT_W'(1);
                    end
                end
                S_RESP: begin
                    if (pmem.rsp_ready) begin
                        r_state <= S_IDLE;
                        r_rdata <= 64'd0;
                        r_err   <= 1'b0;
                    end
                end
                default: r_state <= S_IDLE;
            endcase

            if (w_do_access) begin
                r_rdata <= (w_hit && !w_acc_wen) ? r_mem[w_idx] : 64'd0;
                r_err   <= !w_hit;
            end
        end
    end
endmodule

// File: tb/tb_ysyx_22040386_pmem_responder.sv
// tb/tb_ysyx_22040386_pmem_responder.sv - self-checking bench for the pmem responder (LATENCY=2 and LATENCY=0 builds)
module tb_ysyx_22040386_pmem_responder;
    localparam logic [63:0] BASE = 64'h8000_0000;
    localparam logic [63:0] SPAN = 64'd32768;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   checks = 0;
    int   failures = 0;
    logic [63:0] mdl [0:4095];

    ysyx_22040386_pmem_responder_if a_if ();
    ysyx_22040386_pmem_responder_if b_if ();

    ysyx_22040386_pmem_responder #(.BASE_ADDR(64'h8000_0000), .DEPTH_LOG2(12), .LATENCY(2)) dut_a (
        .clk(clk), .rst(rst), .pmem(a_if));
    ysyx_22040386_pmem_responder #(.BASE_ADDR(64'h8000_0000), .DEPTH_LOG2(12), .LATENCY(0)) dut_b (
        .clk(clk), .rst(rst), .pmem(b_if));

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic bit in_range(input logic [63:0] ad);
        return (ad >= BASE) && (ad < BASE + SPAN);
    endfunction

    function automatic int idx_of(input logic [63:0] ad);
        return int'((ad - BASE) / 64'd8);
    endfunction

    function automatic logic [63:0] merge(input logic [63:0] old, input logic [63:0] wd, input logic [7:0] wm);
        logic [63:0] r;
        r = old;
        for (int i = 0; i < 8; i++) if (wm[i]) r[8*i +: 8] = wd[8*i +: 8];
        return r;
    endfunction

    // One full transaction on DUT A; lat = edges from accept until rsp_valid is sampled high (99 = timeout).
    task automatic do_req(input bit wen, input logic [63:0] addr, input logic [63:0] wdata, input logic [7:0] wmask,
                          output logic [63:0] rdata, output logic err, output int lat, output bit post_idle);
        int n;
        rdata = 64'd0; err = 1'b0; lat = 99; post_idle = 1'b0;
        @(negedge clk);
        a_if.req_valid = 1'b1; a_if.req_wen = wen; a_if.req_addr = addr;
        a_if.req_wdata = wdata; a_if.req_wmask = wmask; a_if.rsp_ready = 1'b0;
        n = 0;
        while (!a_if.req_ready && n < 50) begin @(negedge clk); n++; end
        if (n >= 50) begin a_if.req_valid = 1'b0; return; end
        @(posedge clk);
        @(negedge clk);
        a_if.req_valid = 1'b0;
        n = 0;
        while (!a_if.rsp_valid && n < 50) begin @(negedge clk); n++; end
        if (n >= 50) return;
        lat = n + 1;
        rdata = a_if.rsp_rdata; err = a_if.rsp_err;
        a_if.rsp_ready = 1'b1;
        @(negedge clk);
        a_if.rsp_ready = 1'b0;
        post_idle = (a_if.req_ready === 1'b1) && (a_if.rsp_valid === 1'b0) &&
                    (a_if.rsp_rdata === 64'd0) && (a_if.rsp_err === 1'b0);
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        a_if.req_valid = 1'b1; a_if.req_wen = 1'b0; a_if.req_addr = BASE;
        @(negedge clk);
        rst = 1'b0; a_if.req_valid = 1'b0;
        @(negedge clk);
        checks++; if (a_if.req_ready !== 1'b1) begin failures++; $display("FAIL reset_req_ready act=%b exp=1", a_if.req_ready); end
        checks++; if (a_if.rsp_valid !== 1'b0) begin failures++; $display("FAIL reset_rsp_valid act=%b exp=0", a_if.rsp_valid); end
        checks++; if (a_if.rsp_rdata !== 64'd0) begin failures++; $display("FAIL reset_rdata act=%h exp=0", a_if.rsp_rdata); end
        checks++; if (a_if.rsp_err !== 1'b0) begin failures++; $display("FAIL reset_err act=%b exp=0", a_if.rsp_err); end
        checks++; if (b_if.req_ready !== 1'b1) begin failures++; $display("FAIL reset_b_ready act=%b exp=1", b_if.req_ready); end
    endtask

    task automatic test_write_read();
        logic [63:0] rd; logic er; int lat; bit post;
        do_req(1'b1, 64'h8000_0000, 64'h1122334455667788, 8'hFF, rd, er, lat, post);
        mdl[0] = 64'h1122334455667788;
        checks++; if (lat !== 3) begin failures++; $display("FAIL write_latency act=%0d exp=3", lat); end
        checks++; if (er !== 1'b0 || rd !== 64'd0) begin failures++; $display("FAIL write_rsp act=%b/%h exp=0/0", er, rd); end
        checks++; if (post !== 1'b1) begin failures++; $display("FAIL write_post_idle act=%b exp=1", post); end
        do_req(1'b1, 64'h8000_0000, 64'h0000_0000_0000_AA00, 8'h02, rd, er, lat, post);
        mdl[0] = merge(mdl[0], 64'hAA00, 8'h02);
        checks++; if (er !== 1'b0) begin failures++; $display("FAIL partial_write_err act=%b exp=0", er); end
        do_req(1'b0, 64'h8000_0004, 64'd0, 8'h00, rd, er, lat, post);
        checks++; if (rd !== 64'h112233445566AA88 || er !== 1'b0) begin failures++; $display("FAIL merged_read act=%h/%b exp=112233445566aa88/0", rd, er); end
    endtask

    task automatic test_range();
        logic [63:0] rd; logic er; int lat; bit post;
        do_req(1'b0, 64'h7FFF_FFF8, 64'd0, 8'hFF, rd, er, lat, post);
        checks++; if (er !== 1'b1 || rd !== 64'd0) begin failures++; $display("FAIL below_range act=%b/%h exp=1/0", er, rd); end
        do_req(1'b0, 64'h8000_8000, 64'd0, 8'hFF, rd, er, lat, post);
        checks++; if (er !== 1'b1 || rd !== 64'd0) begin failures++; $display("FAIL above_range act=%b/%h exp=1/0", er, rd); end
        do_req(1'b1, 64'h8000_8000, 64'hDEAD_BEEF_DEAD_BEEF, 8'hFF, rd, er, lat, post);
        checks++; if (er !== 1'b1 || rd !== 64'd0) begin failures++; $display("FAIL miss_write act=%b/%h exp=1/0", er, rd); end
        do_req(1'b0, 64'h8000_0000, 64'd0, 8'h00, rd, er, lat, post);
        checks++; if (rd !== mdl[0] || er !== 1'b0) begin failures++; $display("FAIL reread_after_miss act=%h exp=%h", rd, mdl[0]); end
        do_req(1'b1, 64'h8000_7FF8, 64'h0123_4567_89AB_CDEF, 8'hFF, rd, er, lat, post);
        mdl[4095] = 64'h0123_4567_89AB_CDEF;
        checks++; if (er !== 1'b0) begin failures++; $display("FAIL last_word_write_err act=%b exp=0", er); end
        do_req(1'b0, 64'h8000_7FFF, 64'd0, 8'h00, rd, er, lat, post);
        checks++; if (rd !== mdl[4095] || er !== 1'b0) begin failures++; $display("FAIL last_word_read act=%h/%b exp=%h/0", rd, er, mdl[4095]); end
    endtask

    task automatic test_stall();
        logic [63:0] rd; logic er; int lat; bit post; int n;
        do_req(1'b1, 64'h8000_0028, 64'hCAFE_F00D_1234_5678, 8'hFF, rd, er, lat, post);
        mdl[5] = 64'hCAFE_F00D_1234_5678;
        @(negedge clk);
        a_if.req_valid = 1'b1; a_if.req_wen = 1'b0; a_if.req_addr = 64'h8000_0028; a_if.rsp_ready = 1'b0;
        n = 0;
        while (!a_if.req_ready && n < 50) begin @(negedge clk); n++; end
        @(posedge clk);
        @(negedge clk);
        a_if.req_valid = 1'b0;
        n = 0;
        while (!a_if.rsp_valid && n < 50) begin @(negedge clk); n++; end
        for (int k = 0; k < 5; k++) begin
            checks++; if (a_if.rsp_valid !== 1'b1 || a_if.req_ready !== 1'b0) begin failures++; $display("FAIL stall_handshake k=%0d act=%b/%b exp=1/0", k, a_if.rsp_valid, a_if.req_ready); end
            checks++; if (a_if.rsp_rdata !== mdl[5]) begin failures++; $display("FAIL stall_rdata k=%0d act=%h exp=%h", k, a_if.rsp_rdata, mdl[5]); end
            @(negedge clk);
        end
        a_if.rsp_ready = 1'b1;
        @(negedge clk);
        a_if.rsp_ready = 1'b0;
        checks++; if (a_if.req_ready !== 1'b1 || a_if.rsp_valid !== 1'b0) begin failures++; $display("FAIL stall_release act=%b/%b exp=1/0", a_if.req_ready, a_if.rsp_valid); end
    endtask

    task automatic test_rst_mid();
        logic [63:0] rd; logic er; int lat; bit post; int n; bit seen;
        logic [63:0] v_old, v_new;
        v_old = {$urandom, $urandom};
        v_new = ~v_old;
        do_req(1'b1, 64'h8000_0010, v_old, 8'hFF, rd, er, lat, post);
        mdl[2] = v_old;
        // reset while still in WAIT: write must be discarded
        @(negedge clk);
        a_if.req_valid = 1'b1; a_if.req_wen = 1'b1; a_if.req_addr = 64'h8000_0010;
        a_if.req_wdata = v_new; a_if.req_wmask = 8'hFF; a_if.rsp_ready = 1'b0;
        n = 0;
        while (!a_if.req_ready && n < 50) begin @(negedge clk); n++; end
        @(posedge clk);
        @(negedge clk);
        a_if.req_valid = 1'b0; rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checks++; if (a_if.req_ready !== 1'b1 || a_if.rsp_valid !== 1'b0) begin failures++; $display("FAIL rst_wait_idle act=%b/%b exp=1/0", a_if.req_ready, a_if.rsp_valid); end
        seen = 1'b0;
        repeat (4) begin @(negedge clk); if (a_if.rsp_valid !== 1'b0) seen = 1'b1; end
        checks++; if (seen !== 1'b0) begin failures++; $display("FAIL rst_wait_no_rsp act=%b exp=0", seen); end
        do_req(1'b0, 64'h8000_0010, 64'd0, 8'h00, rd, er, lat, post);
        checks++; if (rd !== mdl[2]) begin failures++; $display("FAIL rst_wait_discard act=%h exp=%h", rd, mdl[2]); end
        // reset in RESP: write already committed
        @(negedge clk);
        a_if.req_valid = 1'b1; a_if.req_wen = 1'b1; a_if.req_addr = 64'h8000_0010;
        a_if.req_wdata = v_new; a_if.req_wmask = 8'hFF;
        n = 0;
        while (!a_if.req_ready && n < 50) begin @(negedge clk); n++; end
        @(posedge clk);
        @(negedge clk);
        a_if.req_valid = 1'b0;
        n = 0;
        while (!a_if.rsp_valid && n < 50) begin @(negedge clk); n++; end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        mdl[2] = v_new;
        checks++; if (a_if.req_ready !== 1'b1 || a_if.rsp_valid !== 1'b0 || a_if.rsp_rdata !== 64'd0) begin failures++; $display("FAIL rst_resp_idle act=%b/%b/%h exp=1/0/0", a_if.req_ready, a_if.rsp_valid, a_if.rsp_rdata); end
        do_req(1'b0, 64'h8000_0010, 64'd0, 8'h00, rd, er, lat, post);
        checks++; if (rd !== mdl[2]) begin failures++; $display("FAIL rst_resp_committed act=%h exp=%h", rd, mdl[2]); end
    endtask

    task automatic test_random();
        logic [63:0] rd, addr, wd, exp_rd; logic er, exp_er; int lat; bit post, wen; logic [7:0] wm; int id;
        for (int i = 0; i < 16; i++) begin
            wd = {$urandom, $urandom};
            do_req(1'b1, BASE + 64'(i * 8), wd, 8'hFF, rd, er, lat, post);
            mdl[i] = wd;
        end
        for (int t = 0; t < 40; t++) begin
            if ($urandom_range(0, 7) == 0)
                addr = ($urandom_range(0, 1) == 1) ? BASE - 64'(8 * $urandom_range(1, 100)) : BASE + SPAN + 64'($urandom_range(0, 1000));
            else
                addr = BASE + 64'(8 * $urandom_range(0, 15)) + 64'($urandom_range(0, 7));
            wen = $urandom_range(0, 1);
            wd = {$urandom, $urandom};
            wm = 8'($urandom);
            exp_er = !in_range(addr);
            exp_rd = 64'd0;
            if (!exp_er) begin
                id = idx_of(addr);
                if (wen) mdl[id] = merge(mdl[id], wd, wm);
                else exp_rd = mdl[id];
            end
            do_req(wen, addr, wd, wm, rd, er, lat, post);
            checks++; if (rd !== exp_rd || er !== exp_er || lat !== 3 || post !== 1'b1) begin
                failures++; $display("FAIL random t=%0d addr=%h wen=%b act=%h/%b/%0d/%b exp=%h/%b/3/1", t, addr, wen, rd, er, lat, post, exp_rd, exp_er);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [63:0] mb [0:3];
        bit wens [10]; logic [63:0] addrs [10]; logic [63:0] wds [10]; logic [7:0] wms [10];
        logic [63:0] exps [10]; bit experr [10];
        int op, last_acc, acc, guard; bit await;
        for (int i = 0; i < 10; i++) begin
            wds[i] = {$urandom, $urandom};
            if (i < 4) begin wens[i] = 1'b1; addrs[i] = BASE + 64'(8 * i); wms[i] = 8'hFF; end
            else if (i == 4) begin wens[i] = 1'b1; addrs[i] = BASE + 64'd8; wms[i] = 8'($urandom); end
            else if (i < 9) begin wens[i] = 1'b0; addrs[i] = BASE + 64'(8 * (i - 5)) + 64'($urandom_range(0, 7)); wms[i] = 8'hFF; end
            else begin wens[i] = 1'b0; addrs[i] = BASE + SPAN; wms[i] = 8'h00; end
            experr[i] = !in_range(addrs[i]);
            exps[i] = 64'd0;
            if (!experr[i]) begin
                if (wens[i]) mb[idx_of(addrs[i])] = merge((i < 4) ? 64'd0 : mb[idx_of(addrs[i])], wds[i], wms[i]);
                else exps[i] = mb[idx_of(addrs[i])];
            end
        end
        @(negedge clk);
        b_if.rsp_ready = 1'b1; b_if.req_valid = 1'b1;
        b_if.req_wen = wens[0]; b_if.req_addr = addrs[0]; b_if.req_wdata = wds[0]; b_if.req_wmask = wms[0];
        op = 0; last_acc = -1; guard = 0; await = 1'b0;
        while (op < 10 && guard < 200) begin
            @(negedge clk);
            guard++;
            if (await) begin
                await = 1'b0;
                checks++; if (b_if.rsp_valid !== 1'b1) begin failures++; $display("FAIL b2b_rsp_next_cycle op=%0d act=%b exp=1", op, b_if.rsp_valid); end
                checks++; if (b_if.rsp_rdata !== exps[op] || b_if.rsp_err !== experr[op]) begin failures++; $display("FAIL b2b_data op=%0d act=%h/%b exp=%h/%b", op, b_if.rsp_rdata, b_if.rsp_err, exps[op], experr[op]); end
                op++;
                if (op < 10) begin
                    b_if.req_wen = wens[op]; b_if.req_addr = addrs[op]; b_if.req_wdata = wds[op]; b_if.req_wmask = wms[op];
                end else begin
                    b_if.req_valid = 1'b0;
                end
            end else if (b_if.req_ready) begin
                acc = cyc + 1;
                if (last_acc >= 0) begin
                    checks++; if (acc - last_acc !== 2) begin failures++; $display("FAIL b2b_spacing op=%0d act=%0d exp=2", op, acc - last_acc); end
                end
                last_acc = acc;
                await = 1'b1;
            end
        end
        checks++; if (op !== 10) begin failures++; $display("FAIL b2b_complete act=%0d exp=10", op); end
        b_if.req_valid = 1'b0;
        @(negedge clk);
        b_if.rsp_ready = 1'b0;
    endtask

    initial begin
        a_if.req_valid = 1'b0; a_if.req_wen = 1'b0; a_if.req_addr = 64'd0;
        a_if.req_wdata = 64'd0; a_if.req_wmask = 8'd0; a_if.rsp_ready = 1'b0;
        b_if.req_valid = 1'b0; b_if.req_wen = 1'b0; b_if.req_addr = 64'd0;
        b_if.req_wdata = 64'd0; b_if.req_wmask = 8'd0; b_if.rsp_ready = 1'b0;
        test_reset();
        test_write_read();
        test_range();
        test_stall();
        test_rst_mid();
        test_random();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog act=timeout exp=finish");
        $fatal(1, "watchdog");
    end
endmodule
